// File: rtl/ifid_pkg.sv
// Shared IF/ID definitions: NOP encoding, instruction field positions and widths,
// the opcode type used by control and ID/EX, and the slot occupancy states.
package ifid_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int OPCODE_LSB = 26;
   localparam int OPCODE_W   = 6;
   localparam int RS_LSB     = 21;
   localparam int RS_W       = 5;
   localparam int RT_LSB     = 16;
   localparam int RT_W       = 5;
   localparam int RD_LSB     = 11;
   localparam int RD_W       = 5;
   localparam int IMM_LSB    = 0;
   localparam int IMM_W      = 16;
   localparam int FUNCT_LSB  = 0;
   localparam int FUNCT_W    = 6;

   typedef enum logic [OPCODE_W-1:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/ifid_perf_counters.sv
// Two saturating event counters (issued instructions, stall cycles); count on the edge
// after the enable is sampled, stick at all-ones. No backpressure.
module ifid_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_inc,
   input  logic             stall_inc,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (issue_inc && (issued_cnt != {CNT_W{1'b1}}))
            issued_cnt <= issued_cnt + CNT_W'(1);
         if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register presenting pre-split fields to decode; 1-cycle latency,
// stall holds the slot and drops the fetched word, flush squashes it. Counters under IFID_PERF_COUNTERS_EN.
module ifid_stage
   import ifid_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr_in,
   input  logic [PC_W-1:0]      pc_in,
   input  logic                 fetch_valid,
   input  logic                 stall,
   input  logic                 flush,
   output logic [31:0]          instr_out,
   output logic [PC_W-1:0]      pc_out,
   output logic [PC_W-1:0]      pc_plus4_out,
   output logic                 valid_out,
   output logic [OPCODE_W-1:0]  opcode,
   output logic [RS_W-1:0]      rs,
   output logic [RT_W-1:0]      rt,
   output logic [RD_W-1:0]      rd,
   output logic [IMM_W-1:0]     imm16,
   output logic [FUNCT_W-1:0]   funct
`ifdef IFID_PERF_COUNTERS_EN
   ,
   output logic [CNT_W-1:0]     issued_cnt,
   output logic [CNT_W-1:0]     stall_cnt
`endif
);

   slot_state_t     state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic [PC_W-1:0] pc_q, pc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SLOT_EMPTY;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   // Flush beats stall; a stalled slot ignores fetch entirely.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush) begin
         state_d = SLOT_EMPTY;
         instr_d = NOP_INSTR;
      end else if (!stall) begin
         state_d = fetch_valid ? SLOT_FULL : SLOT_EMPTY;
         instr_d = fetch_valid ? instr_in : NOP_INSTR;
         pc_d    = pc_in;
      end
   end

   assign valid_out    = (state_q == SLOT_FULL);
   assign instr_out    = valid_out ? instr_q : NOP_INSTR;
   assign pc_out       = pc_q;
   assign pc_plus4_out = pc_q + PC_W'(4);

   assign opcode = instr_out[OPCODE_LSB +: OPCODE_W];
   assign rs     = instr_out[RS_LSB     +: RS_W];
   assign rt     = instr_out[RT_LSB     +: RT_W];
   assign rd     = instr_out[RD_LSB     +: RD_W];
   assign imm16  = instr_out[IMM_LSB    +: IMM_W];
   assign funct  = instr_out[FUNCT_LSB  +: FUNCT_W];

`ifdef IFID_PERF_COUNTERS_EN
   logic issue_inc, stall_inc;

   assign issue_inc = !flush && !stall && fetch_valid;
   assign stall_inc = !flush && stall && (state_q == SLOT_FULL);

   ifid_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk        (clk),
      .reset      (reset),
      .issue_inc  (issue_inc),
      .stall_inc  (stall_inc),
      .issued_cnt (issued_cnt),
      .stall_cnt  (stall_cnt)
   );
`endif

endmodule

// File: doc/ifid_stage.md
# ifid_stage

IF/ID pipeline register sitting between instruction fetch and the ID/EX stage. It captures the fetched instruction word and its PC and presents them to decode as pre-split fields. It supports load-use stalls and branch flushes, and tracks a valid bit so that squashed slots reach decode as NOPs. Optional performance counters record issued instructions and stall cycles.

## Interface
Parameters:
- `PC_W`, default 32: program counter width.
- `CNT_W`, default 32: width of each performance counter (only used when counters are compiled in).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `instr_in`  in  32: fetched instruction word.
- `pc_in`  in  PC_W: PC of `instr_in`.
- `fetch_valid`  in  1: `instr_in`/`pc_in` are meaningful this cycle.
- `stall`  in  1: hazard unit hold request (load-use).
- `flush`  in  1: squash the held instruction (taken branch/jump).
- `instr_out`  out  32: held instruction; forced to NOP (32'h0) when not valid.
- `pc_out`  out  PC_W: held PC.
- `pc_plus4_out`  out  PC_W: `pc_out + 4`, modulo 2^PC_W.
- `valid_out`  out  1: the held slot is a real instruction.
- `opcode`  out  6: `instr_out[31:26]`.
- `rs`  out  5: `instr_out[25:21]`.
- `rt`  out  5: `instr_out[20:16]`.
- `rd`  out  5: `instr_out[15:11]`.
- `imm16`  out  16: `instr_out[15:0]`.
- `funct`  out  6: `instr_out[5:0]`.
- `issued_cnt`  out  CNT_W: number of valid instructions passed to decode (macro only).
- `stall_cnt`  out  CNT_W: number of cycles held by `stall` with a valid instruction (macro only).

## Operation
- State: `instr_q`, `pc_q`, `valid_q`, plus counters when enabled.
- Two-state occupancy view derived from `valid_q`: EMPTY (0) and FULL (1).
- Per-edge priority: reset > flush > stall > load.
  - **flush**: `valid_q` <= 0 and `instr_q` <= NOP; `pc_q` unchanged. Flush wins even when `stall` is also high.
  - **stall** (no flush): all registers hold, `fetch_valid` is ignored, and the fetched word is dropped. Fetch must also hold its PC under the same `stall`.
  - **load**: `instr_q` <= `instr_in`, `pc_q` <= `pc_in`, `valid_q` <= `fetch_valid`. If `fetch_valid` = 0, `instr_q` <= NOP.
- Field outputs are combinational slices of `instr_out`, so an invalid slot decodes as opcode 0 / funct 0, which is a NOP.
- `pc_plus4_out` is a combinational adder on `pc_q`; carry out of the MSB is discarded.

## Timing
- Reset values: `instr_out` = 0, `pc_out` = 0, `pc_plus4_out` = 4, `valid_out` = 0, all fields 0, both counters 0.
- Latency: one cycle from `instr_in` to `instr_out` when neither `stall` nor `flush` is active.
- `stall` held for N cycles holds the outputs for exactly N cycles. The instruction presented on the edge after `stall` drops is loaded on that edge.
- `flush` takes effect on the same edge: next cycle `valid_out` = 0. The instruction fetched the following cycle loads normally.
- Reset asserted mid-operation clears state immediately (asynchronous). The first load happens on the first rising edge after `reset` deasserts.
- Counters:
  - `issued_cnt` increments on any edge where the stage loads with `fetch_valid` = 1 (flush and stall edges excluded).
  - `stall_cnt` increments on edges where `stall` = 1, `flush` = 0, and `valid_q` = 1.
  - Both counters saturate at all-ones and do not wrap.

## Configuration
- `IFID_PERF_COUNTERS_EN` defined: `issued_cnt` and `stall_cnt` ports and their logic exist as described.
- Macro undefined: both ports are absent and no counter flops are synthesised. All other behaviour is identical.

## Structure
- Shared package `ifid_pkg` holds:
  - `NOP_INSTR` (32'h0);
  - field bit positions and widths (opcode, rs, rt, rd, imm, funct);
  - the opcode typedef used by the control unit and ID/EX.
- One sub-module, `ifid_perf_counters`: two saturating CNT_W counters with increment enables. It is instantiated only under `IFID_PERF_COUNTERS_EN`.

## Test plan
- **Reset:** assert `reset` mid-cycle while holding a valid instruction → outputs go to the reset values without a clock edge; `pc_plus4_out` = 4.
- **Load:** `instr_in` = 32'h8C220004, `pc_in` = 0x10, `fetch_valid` = 1 → next cycle: opcode 0x23, rs 1, rt 2, imm16 0x0004, `pc_plus4_out` 0x14, `valid_out` 1, `issued_cnt` 1.
- **Stall:** stall 3 cycles while fetch presents a different word → outputs stay 0x8C220004 for 3 cycles, `stall_cnt` = 3, `issued_cnt` unchanged. The word presented after release loads.
- **Flush with stall:** assert `flush` and `stall` together → next cycle `valid_out` 0 and `instr_out` 0; `stall_cnt` does not increment.
- **Bubble and wrap:** `fetch_valid` = 0 → `instr_out` 0 and `valid_out` 0. Then load `pc_in` = 32'hFFFFFFFC → `pc_plus4_out` = 0.
- **Saturation:** with CNT_W = 4, stall 20 cycles → `stall_cnt` sticks at 15.
